// File: rtl/nios_dut_pio_arbiter.sv
// nios_dut_pio_arbiter: round-robin arbiter turning requester write/set/clear ops into Avalon writes on one 8-bit PIO
// Ports: clk, reset_n (sync, active low); req/req_op/req_data per-requester request level, op and value/mask;
// ack one-cycle grant completion; err reserved-op pulse; m_* Avalon-MM master to the PIO slave;
// shadow predicted PIO out_port; busy high while writing or settling.
module nios_dut_pio_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic [2:0]             m_address,
  output logic                   m_chipselect,
  output logic                   m_write_n,
  output logic [31:0]            m_writedata,
  output logic [7:0]             shadow,
  output logic                   busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] HOLD_LOAD = HOLD_CYCLES > 0 ? 8'(HOLD_CYCLES - 1) : 8'd0;
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
  state_t state, state_nx;
  logic [IW-1:0] grant, last_grant, pick, cand;
  logic [1:0] op;
  logic [7:0] data, cnt;
  logic found, strobe;
  logic [1:0] ops [NUM_REQ];
  logic [7:0] dats [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ops[g] = req_op[2*g +: 2];
    assign dats[g] = req_data[8*g +: 8];
  end
  // search upward from the requester after the last one served, so it ends up lowest priority
  always_comb begin
    found = 1'b0;
    pick = last_grant;
    cand = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? WRITE : IDLE) :
               state == WRITE ? (HOLD_CYCLES > 0 ? HOLD : IDLE) :
               (cnt == 8'd0 ? IDLE : HOLD);
    strobe = state == WRITE && op != 2'b11;
    ack = state == WRITE ? NUM_REQ'(1) << grant : '0;
    err = state == WRITE && op == 2'b11;
    m_chipselect = strobe;
    m_write_n = !strobe;
    m_address = !strobe ? 3'd0 : op == 2'b01 ? 3'd4 : op == 2'b10 ? 3'd5 : 3'd0;
    m_writedata = strobe ? {24'd0, data} : 32'd0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      op <= 2'b00;
      data <= 8'd0;
      cnt <= 8'd0;
      shadow <= 8'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        grant <= pick;
        op <= ops[pick];
        data <= dats[pick];
      end
      if (state == WRITE) begin
        last_grant <= grant;
        cnt <= HOLD_LOAD;
        shadow <= op == 2'b00 ? data : op == 2'b01 ? shadow | data : op == 2'b10 ? shadow & ~data : shadow;
      end else if (state == HOLD) begin
        cnt <= cnt - 8'd1;
      end
    end
  end
endmodule
